dice_roll_controller: RTL and testbench
=======================================

DICE_ROLL_CONTROLLER -- requirements
Module: dice_roll_controller

Interface
REQ-001 Parameter TICK_DIV, default 4: clocks per face step while spinning, range 2..65535.
REQ-002 Parameter SLOW_STEPS, default 3: face steps taken during deceleration, range 1..8; used only when DICE_SLOWDOWN_EN is defined.
REQ-003 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port roll, input, 1: level roll request; high means spin.
REQ-006 Port cnt, output, 3: current face 1..6, drives the face decoder's cnt input directly.
REQ-007 Port busy, output, 1: high in SPIN and SLOW.
REQ-008 Port valid, output, 1: high in SHOW; cnt is the rolled result.
REQ-009 Port done, output, 1: single-cycle pulse on entry to SHOW.

Function
REQ-010 States SHALL be IDLE, SPIN, SLOW, SHOW.
REQ-011 IDLE with roll=1 -> SPIN at the next edge; prescaler cleared to 0.
REQ-012 In SPIN, cnt SHALL advance by one every TICK_DIV clocks; first advance TICK_DIV clocks after SPIN entry.
REQ-013 Advance sequence 1,2,3,4,5,6,1. The values 0 and 7 SHALL never appear on cnt.
REQ-014 SPIN with roll=0 -> SLOW (macro defined) or SHOW (macro undefined); prescaler cleared.
REQ-015 If roll falls on a tick cycle, the advance SHALL occur on the same edge as the state transition.
REQ-016 In SLOW, step k (k=1..SLOW_STEPS) occurs TICK_DIV<<k clocks after the previous step or SLOW entry.
REQ-017 After step SLOW_STEPS, SLOW -> SHOW on the same edge.
REQ-018 roll is ignored in SLOW.
REQ-019 Entering SHOW SHALL assert done for exactly one cycle and valid until exit; cnt is held.
REQ-020 SHOW with roll=1 -> SPIN; valid drops on that edge and cnt continues from the held value.
REQ-021 busy=1 exactly in SPIN and SLOW; valid and busy are never both 1.
REQ-022 The prescaler SHALL be wide enough for TICK_DIV<<SLOW_STEPS without overflow.

Reset
REQ-023 While reset=1, outputs SHALL be immediately cnt=3'd1, busy=0, valid=0, done=0; state IDLE; prescaler 0.
REQ-024 Reset asserted mid-SPIN/SLOW/SHOW SHALL abort with no done pulse.
REQ-025 After reset release, the first transition requires roll=1 sampled on a clk edge.

Configuration
REQ-026 Macro DICE_SLOWDOWN_EN defined: SLOW state and geometric deceleration present, per REQ-016 to REQ-018.
REQ-027 Macro DICE_SLOWDOWN_EN undefined: no SLOW state or logic; SPIN goes directly to SHOW on roll=0; SLOW_STEPS is unused.

Structure
REQ-028 Package dice_pkg SHALL hold the state enum typedef, the FACE_MIN=1 and FACE_MAX=6 constants, and the face width (3).
REQ-029 Sub-module dice_tick_gen: loadable-interval prescaler with clear input and tick output; it owns the prescaler counter.

Verification
REQ-030 Reset scenario: reset pulse mid-SPIN with TICK_DIV=4 -> cnt=1, busy=0, valid=0 immediately; no done pulse.
REQ-031 No-slow step count: macro undefined, TICK_DIV=4, roll high 9 cycles from IDLE, cnt=1 -> two advances, SHOW with cnt=3, one done pulse, valid=1.
REQ-032 Wrap-around: roll held 1+6*4 cycles from cnt=5 -> sequence 6,1,2,3,4,5; cnt never 0 or 7.
REQ-033 Slowdown: macro defined, TICK_DIV=4, SLOW_STEPS=3, release at cnt=3 -> advances 8, 24 and 56 cycles after release; SHOW with cnt=6; done on the same edge as the last advance.
REQ-034 Re-roll: in SHOW with cnt=4, roll=1 -> valid=0 and busy=1 next edge; first advance to 5 after 4 cycles.
REQ-035 Boundaries: roll falling on a tick edge -> advance and transition coincide; roll toggled in SLOW -> no effect.

Source files
------------

// File: rtl/dice_pkg.sv
// Shared types and constants for the dice roll controller.
// Configuration macro: DICE_SLOWDOWN_EN adds the SLOW deceleration state.
package dice_pkg;

   localparam int unsigned FACE_W = 3;
   localparam logic [FACE_W-1:0] FACE_MIN = 3'd1;
   localparam logic [FACE_W-1:0] FACE_MAX = 3'd6;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SPIN = 2'd1,
      SHOW = 2'd2
`ifdef DICE_SLOWDOWN_EN
      , SLOW = 2'd3
`endif
   } state_t;

   // Next face in the 1..6 cycle; anything outside the range folds back to 1.
   function automatic logic [FACE_W-1:0] next_face(input logic [FACE_W-1:0] f);
      return ((f >= FACE_MAX) || (f < FACE_MIN)) ? FACE_MIN : f + 3'd1;
   endfunction

endpackage

// File: rtl/dice_tick_gen.sv
// Loadable-interval prescaler: tick is high on the last clock of each interval.
module dice_tick_gen #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear,
   input  logic [W-1:0] interval,
   output logic         tick
);

   logic [W-1:0] count;

   assign tick = (count == (interval - W'(1)));

   // Free-running count, restarted by clear or at the end of each interval.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         count <= '0;
      else if (clear || tick)
         count <= '0;
      else
         count <= count + W'(1);
   end

endmodule

// File: rtl/dice_roll_controller.sv
// Dice roll controller: spins a 1..6 face while roll is held, then reports
// the result. Configuration macro: DICE_SLOWDOWN_EN inserts a geometric
// deceleration phase (SLOW) between SPIN and SHOW.
module dice_roll_controller
   import dice_pkg::*;
#(
   parameter int unsigned TICK_DIV   = 4,
   parameter int unsigned SLOW_STEPS = 3
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                roll,
   output logic [FACE_W-1:0]   cnt,
   output logic                busy,
   output logic                valid,
   output logic                done
);

   // Sized for the widest slowdown interval so both builds share one width.
   localparam int unsigned PW = $clog2(TICK_DIV) + SLOW_STEPS + 1;

   state_t        state;
   logic          clear;
   logic          tick;
   logic [PW-1:0] interval;

`ifdef DICE_SLOWDOWN_EN
   logic [3:0]    step;

   // Interval doubles with every deceleration step: TICK_DIV << (step+1).
   always_comb begin
      interval = PW'(TICK_DIV);
      if (state == SLOW)
         interval = PW'(TICK_DIV << (32'(step) + 32'd1));
   end
`else
   assign interval = PW'(TICK_DIV);
`endif

   // Prescaler restarts on every state entry; it only runs in SPIN and SLOW.
   always_comb begin
      clear = 1'b1;
      case (state)
         SPIN:    clear = ~roll;
`ifdef DICE_SLOWDOWN_EN
         SLOW:    clear = 1'b0;
`endif
         default: clear = 1'b1;
      endcase
   end

   dice_tick_gen #(
      .W (PW)
   ) u_tick (
      .clk      (clk),
      .reset    (reset),
      .clear    (clear),
      .interval (interval),
      .tick     (tick)
   );

   // Roll FSM with registered face and status outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= FACE_MIN;
         busy  <= 1'b0;
         valid <= 1'b0;
         done  <= 1'b0;
`ifdef DICE_SLOWDOWN_EN
         step  <= '0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE, SHOW: begin
               if (roll) begin
                  state <= SPIN;
                  busy  <= 1'b1;
                  valid <= 1'b0;
               end
            end
            SPIN: begin
               // A tick coinciding with release still advances on this edge.
               if (tick)
                  cnt <= next_face(cnt);
               if (!roll) begin
`ifdef DICE_SLOWDOWN_EN
                  state <= SLOW;
                  step  <= '0;
`else
                  state <= SHOW;
                  busy  <= 1'b0;
                  valid <= 1'b1;
                  done  <= 1'b1;
`endif
               end
            end
`ifdef DICE_SLOWDOWN_EN
            SLOW: begin
               if (tick) begin
                  cnt <= next_face(cnt);
                  if (step == 4'(SLOW_STEPS - 1)) begin
                     state <= SHOW;
                     busy  <= 1'b0;
                     valid <= 1'b1;
                     done  <= 1'b1;
                  end else begin
                     step <= step + 4'd1;
                  end
               end
            end
`endif
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dice_roll_controller.sv
// Testbench for dice_roll_controller (TICK_DIV=4, SLOW_STEPS=3).
// Follows DICE_SLOWDOWN_EN to choose the release behaviour it expects.
module tb_dice_roll_controller;

   logic       clk;
   logic       reset;
   logic       roll;
   logic [2:0] cnt;
   logic       busy;
   logic       valid;
   logic       done;

   int errors = 0;
   int checks = 0;
   int held   = 0;

   typedef struct {
      logic       roll;
      logic [2:0] cnt;
      logic       busy;
      logic       valid;
      logic       done;
   } vec_t;

   vec_t vecs[$];

   dice_roll_controller #(
      .TICK_DIV   (4),
      .SLOW_STEPS (3)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .roll  (roll),
      .cnt   (cnt),
      .busy  (busy),
      .valid (valid),
      .done  (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic outs(input string name, input int c, input int b, input int v, input int d);
      chk({name, ".cnt"},   32'(cnt),   32'(c));
      chk({name, ".busy"},  32'(busy),  32'(b));
      chk({name, ".valid"}, 32'(valid), 32'(v));
      chk({name, ".done"},  32'(done),  32'(d));
   endtask

   task automatic tick1();
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic r, input int c, input logic b, input logic v, input logic d);
      vec_t x;
      x.roll  = r;
      x.cnt   = 3'(c);
      x.busy  = b;
      x.valid = v;
      x.done  = d;
      vecs.push_back(x);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: run did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int e;
      int seq [6];
      reset = 1'b0;
      roll  = 1'b0;

      // Asynchronous reset: outputs settle before any clock edge.
      #2 reset = 1'b1;
      #1 outs("reset_async", 1, 0, 0, 0);
      tick1();
      tick1();
      outs("reset_held", 1, 0, 0, 0);
      reset = 1'b0;

`ifndef DICE_SLOWDOWN_EN
      // From IDLE: roll high for 9 edges, two advances, release -> SHOW at 3.
      add(0, 1, 0, 0, 0);
      for (int k = 0; k < 4; k++) add(1, 1, 1, 0, 0);
      for (int k = 0; k < 4; k++) add(1, 2, 1, 0, 0);
      add(1, 3, 1, 0, 0);
      add(0, 3, 0, 1, 1);
      add(0, 3, 0, 1, 0);
      add(0, 3, 0, 1, 0);
      // Re-roll from SHOW; release lands on the second tick edge.
      for (int k = 0; k < 4; k++) add(1, 3, 1, 0, 0);
      for (int k = 0; k < 4; k++) add(1, 4, 1, 0, 0);
      add(0, 5, 0, 1, 1);
      add(0, 5, 0, 1, 0);

      for (int k = 0; k < vecs.size(); k++) begin
         roll = vecs[k].roll;
         tick1();
         outs($sformatf("vec%0d", k), int'(vecs[k].cnt), int'(vecs[k].busy),
              int'(vecs[k].valid), int'(vecs[k].done));
      end

      // Wrap-around: 1 + 6*4 edges from cnt=5 gives 6,1,2,3,4,5.
      seq = '{6, 1, 2, 3, 4, 5};
      roll = 1'b1;
      tick1();
      outs("wrap_entry", 5, 1, 0, 0);
      e = 5;
      for (int i = 1; i <= 24; i++) begin
         tick1();
         if (i % 4 == 0) e = seq[i/4 - 1];
         chk($sformatf("wrap%0d.cnt", i), 32'(cnt), 32'(e));
         chk($sformatf("wrap%0d.legal", i), 32'(cnt >= 3'd1 && cnt <= 3'd6), 32'd1);
         chk($sformatf("wrap%0d.done", i), 32'(done), 32'd0);
      end
      roll = 1'b0;
      tick1();
      outs("wrap_show", 5, 0, 1, 1);
      held = 5;
`else
      // Spin up to cnt=3, release off-tick, then decelerate 8/16/32 clocks.
      roll = 1'b1;
      tick1();
      outs("slow_spin_entry", 1, 1, 0, 0);
      for (int i = 1; i <= 8; i++) begin
         tick1();
         chk($sformatf("slow_spin%0d.cnt", i), 32'(cnt), (i < 4) ? 32'd1 : (i < 8) ? 32'd2 : 32'd3);
      end
      roll = 1'b0;
      tick1();
      outs("slow_entry", 3, 1, 0, 0);
      for (int i = 1; i <= 56; i++) begin
         // Toggle roll during SLOW; it must have no effect.
         roll = (i < 50) ? 1'(i % 2) : 1'b0;
         tick1();
         e = (i < 8) ? 3 : (i < 24) ? 4 : (i < 56) ? 5 : 6;
         chk($sformatf("slow%0d.cnt", i), 32'(cnt), 32'(e));
         chk($sformatf("slow%0d.busy", i), 32'(busy), (i < 56) ? 32'd1 : 32'd0);
         chk($sformatf("slow%0d.valid", i), 32'(valid), (i < 56) ? 32'd0 : 32'd1);
         chk($sformatf("slow%0d.done", i), 32'(done), (i == 56) ? 32'd1 : 32'd0);
      end
      tick1();
      outs("slow_hold", 6, 0, 1, 0);
      held = 6;
`endif

      // Re-roll from SHOW, then abort mid-SPIN with an asynchronous reset.
      roll = 1'b1;
      tick1();
      outs("reroll_entry", held, 1, 0, 0);
      tick1();
      tick1();
      outs("reroll_spin", held, 1, 0, 0);
      #3 reset = 1'b1;
      #1 outs("abort_async", 1, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         tick1();
         outs($sformatf("abort_hold%0d", i), 1, 0, 0, 0);
      end
      reset = 1'b0;
      roll  = 1'b0;
      tick1();
      outs("post_reset_idle", 1, 0, 0, 0);
      roll = 1'b1;
      tick1();
      outs("post_reset_spin", 1, 1, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
